// File: rtl/guitar_io_arbiter.sv
// Shares the regfile write port between the processor and the guitar/frame capture path.
// Debounced button state and frame count are written into idle processor cycles, stalling the processor if starved.
module guitar_io_arbiter #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int INPUT_REG       = 28,
    parameter int FRAME_REG       = 29,
    parameter int MAX_WAIT        = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [5:0]  guitar_raw,
    input  logic        vsync_n,
    input  logic        proc_we,
    input  logic [4:0]  proc_wreg,
    input  logic [31:0] proc_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_wreg,
    output logic [31:0] rf_wdata,
    output logic        stall_req,
    output logic [5:0]  buttons_db,
    output logic [15:0] frame_count,
    output logic        io_busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MAX_WAIT);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STALL} state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d, wait_inc;
    logic [5:0]        raw_s1_q, raw_s2_q;
    logic              vs_s1_q, vs_s2_q, vs_hist_q, vs_fall;
    logic [DB_W-1:0]   db_cnt_q [6];
    logic [DB_W-1:0]   db_cnt_d [6];
    logic [5:0]        buttons_db_q, buttons_db_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              pend_btn_q, pend_btn_d, pend_frame_q, pend_frame_d;
    logic              in_stall, blocked, grant_io, grant_btn, grant_frame;

    assign vs_fall       = vs_hist_q & ~vs_s2_q;
    assign frame_count_d = vs_fall ? frame_count_q + 16'd1 : frame_count_q;
    assign io_busy       = pend_btn_q | pend_frame_q;
    assign blocked       = io_busy & proc_we;
    assign buttons_db    = buttons_db_q;
    assign frame_count   = frame_count_q;

    // Each bit has its own counter; a level is accepted only after staying different for DEBOUNCE_CYCLES.
    always_comb begin
        buttons_db_d = buttons_db_q;
        for (int i = 0; i < 6; i++) begin
            db_cnt_d[i] = '0;
            if (raw_s2_q[i] != buttons_db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    buttons_db_d[i] = raw_s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // A set event on the grant edge wins over the clear, so a fresh value is never lost.
    always_comb begin
        pend_btn_d   = (buttons_db_d != buttons_db_q) | (pend_btn_q & ~grant_btn);
        pend_frame_d = vs_fall | (pend_frame_q & ~grant_frame);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            raw_s1_q      <= '0;
            raw_s2_q      <= '0;
            vs_s1_q       <= 1'b1;
            vs_s2_q       <= 1'b1;
            vs_hist_q     <= 1'b1;
            buttons_db_q  <= '0;
            frame_count_q <= '0;
            pend_btn_q    <= 1'b0;
            pend_frame_q  <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            raw_s1_q      <= guitar_raw;
            raw_s2_q      <= raw_s1_q;
            vs_s1_q       <= vsync_n;
            vs_s2_q       <= vs_s1_q;
            vs_hist_q     <= vs_s2_q;
            buttons_db_q  <= buttons_db_d;
            frame_count_q <= frame_count_d;
            pend_btn_q    <= pend_btn_d;
            pend_frame_q  <= pend_frame_d;
            for (int i = 0; i < 6; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // The blocked cycle seen in IDLE counts too, so STALL lands on blocked cycle MAX_WAIT+1.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wait_inc   = wait_cnt_q + WC_W'(1);
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (blocked) begin
                    wait_cnt_d = wait_inc;
                    state_d    = (wait_inc >= WC_MAX) ? ST_STALL : ST_WAIT;
                end else begin
                    wait_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            ST_STALL: begin
                wait_cnt_d = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                wait_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // During STALL the I/O write owns the port and any processor write is dropped.
    always_comb begin
        in_stall    = (state_q == ST_STALL);
        stall_req   = in_stall;
        grant_io    = io_busy & (in_stall | ~proc_we);
        grant_btn   = grant_io & pend_btn_q;
        grant_frame = grant_io & ~pend_btn_q & pend_frame_q;
        rf_we       = resetn & ((proc_we & ~in_stall) | grant_io);
        rf_wreg     = proc_wreg;
        rf_wdata    = proc_wdata;
        if (grant_btn) begin
            rf_wreg  = 5'(INPUT_REG);
            rf_wdata = {26'b0, buttons_db_q};
        end else if (grant_frame) begin
            rf_wreg  = 5'(FRAME_REG);
            rf_wdata = {16'b0, frame_count_q};
        end
    end

endmodule

// File: tb/tb_guitar_io_arbiter.sv
// Directed bench for guitar_io_arbiter with DEBOUNCE_CYCLES=4 and MAX_WAIT=3.
// Inputs change 1 time unit after a rising edge; outputs are checked before the next edge.
module tb_guitar_io_arbiter;

  logic        clock;
  logic        resetn;
  logic [5:0]  guitar_raw;
  logic        vsync_n;
  logic        proc_we;
  logic [4:0]  proc_wreg;
  logic [31:0] proc_wdata;
  logic        rf_we;
  logic [4:0]  rf_wreg;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [5:0]  buttons_db;
  logic [15:0] frame_count;
  logic        io_busy;

  int n_pass;
  int n_total;

  guitar_io_arbiter #(
    .DEBOUNCE_CYCLES(4),
    .INPUT_REG(28),
    .FRAME_REG(29),
    .MAX_WAIT(3)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .guitar_raw(guitar_raw),
    .vsync_n(vsync_n),
    .proc_we(proc_we),
    .proc_wreg(proc_wreg),
    .proc_wdata(proc_wdata),
    .rf_we(rf_we),
    .rf_wreg(rf_wreg),
    .rf_wdata(rf_wdata),
    .stall_req(stall_req),
    .buttons_db(buttons_db),
    .frame_count(frame_count),
    .io_busy(io_busy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; proc_we = 1'b1; proc_wreg = 5'd3; proc_wdata = 32'h1111_2222;
    guitar_raw = 6'h00; vsync_n = 1'b1;
    #2;
    n_total++; if (buttons_db !== 6'h00) $display("FAIL reset_db: got %h want 00", buttons_db); else n_pass++;
    n_total++; if (frame_count !== 16'h0000) $display("FAIL reset_frame: got %h want 0000", frame_count); else n_pass++;
    n_total++; if (io_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", io_busy); else n_pass++;
    n_total++; if (stall_req !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_req); else n_pass++;
    n_total++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we: got %b want 0", rf_we); else n_pass++;
    tick; tick;
    resetn = 1'b1; proc_we = 1'b0;
    tick;
    guitar_raw = 6'h01;
    repeat (3) tick;
    resetn = 1'b0; proc_we = 1'b1;
    #1;
    n_total++; if (buttons_db !== 6'h00) $display("FAIL midreset_db: got %h want 00", buttons_db); else n_pass++;
    n_total++; if (stall_req !== 1'b0) $display("FAIL midreset_stall: got %b want 0", stall_req); else n_pass++;
    n_total++; if (rf_we !== 1'b0) $display("FAIL midreset_rf_we: got %b want 0", rf_we); else n_pass++;
    n_total++; if (io_busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", io_busy); else n_pass++;
    tick;
    proc_we = 1'b0; resetn = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick;
      n_total++; if (buttons_db !== 6'h00) $display("FAIL debounce_early c%0d: got %h want 00", c, buttons_db); else n_pass++;
    end
    tick;
    n_total++; if (buttons_db !== 6'h01) $display("FAIL debounce_c6: got %h want 01", buttons_db); else n_pass++;
    n_total++; if (rf_we !== 1'b1) $display("FAIL btn_write_we: got %b want 1", rf_we); else n_pass++;
    n_total++; if (rf_wreg !== 5'd28) $display("FAIL btn_write_reg: got %0d want 28", rf_wreg); else n_pass++;
    n_total++; if (rf_wdata !== 32'h1) $display("FAIL btn_write_data: got %h want 00000001", rf_wdata); else n_pass++;
    tick;
    n_total++; if (rf_we !== 1'b0) $display("FAIL btn_write_done_we: got %b want 0", rf_we); else n_pass++;
    n_total++; if (io_busy !== 1'b0) $display("FAIL btn_write_done_busy: got %b want 0", io_busy); else n_pass++;
  endtask

  task automatic test_glitch;
    tick;
    guitar_raw = 6'h05;
    repeat (3) tick;
    guitar_raw = 6'h01;
    for (int c = 0; c < 8; c++) begin
      tick;
      n_total++; if (buttons_db !== 6'h01) $display("FAIL glitch_db c%0d: got %h want 01", c, buttons_db); else n_pass++;
      n_total++; if (io_busy !== 1'b0) $display("FAIL glitch_busy c%0d: got %b want 0", c, io_busy); else n_pass++;
    end
  endtask

  task automatic test_frame_wrap;
    tick;
    force dut.frame_count_q = 16'hFFFF;
    tick;
    release dut.frame_count_q;
    vsync_n = 1'b0;
    tick; tick;
    n_total++; if (frame_count !== 16'hFFFF) $display("FAIL wrap_before: got %h want ffff", frame_count); else n_pass++;
    n_total++; if (io_busy !== 1'b0) $display("FAIL wrap_before_busy: got %b want 0", io_busy); else n_pass++;
    tick;
    n_total++; if (frame_count !== 16'h0000) $display("FAIL wrap_count: got %h want 0000", frame_count); else n_pass++;
    n_total++; if (rf_we !== 1'b1) $display("FAIL wrap_we: got %b want 1", rf_we); else n_pass++;
    n_total++; if (rf_wreg !== 5'd29) $display("FAIL wrap_reg: got %0d want 29", rf_wreg); else n_pass++;
    n_total++; if (rf_wdata !== 32'h0) $display("FAIL wrap_data: got %h want 00000000", rf_wdata); else n_pass++;
    tick;
    n_total++; if (io_busy !== 1'b0) $display("FAIL wrap_done_busy: got %b want 0", io_busy); else n_pass++;
    tick; tick;
    n_total++; if (frame_count !== 16'h0000) $display("FAIL wrap_level_hold: got %h want 0000", frame_count); else n_pass++;
    vsync_n = 1'b1;
    repeat (3) tick;
  endtask

  task automatic test_priority_coalesce;
    tick;
    guitar_raw = 6'h03;
    repeat (3) tick;
    vsync_n = 1'b0;
    tick; tick;
    n_total++; if (io_busy !== 1'b0) $display("FAIL prio_pre_busy: got %b want 0", io_busy); else n_pass++;
    tick;
    n_total++; if (frame_count !== 16'h0001) $display("FAIL prio_frame: got %h want 0001", frame_count); else n_pass++;
    n_total++; if (rf_wreg !== 5'd28) $display("FAIL prio_first_reg: got %0d want 28", rf_wreg); else n_pass++;
    n_total++; if (rf_wdata !== 32'h3) $display("FAIL prio_first_data: got %h want 00000003", rf_wdata); else n_pass++;
    vsync_n = 1'b1;
    tick;
    n_total++; if (rf_we !== 1'b1) $display("FAIL prio_second_we: got %b want 1", rf_we); else n_pass++;
    n_total++; if (rf_wreg !== 5'd29) $display("FAIL prio_second_reg: got %0d want 29", rf_wreg); else n_pass++;
    n_total++; if (rf_wdata !== 32'h1) $display("FAIL prio_second_data: got %h want 00000001", rf_wdata); else n_pass++;
    tick;
    n_total++; if (rf_we !== 1'b0) $display("FAIL prio_done_we: got %b want 0", rf_we); else n_pass++;

    tick;
    guitar_raw = 6'h13; proc_we = 1'b1; proc_wreg = 5'd7; proc_wdata = 32'h1234_5678;
    tick;
    guitar_raw = 6'h33;
    repeat (5) tick;
    n_total++; if (buttons_db !== 6'h13) $display("FAIL coal_db1: got %h want 13", buttons_db); else n_pass++;
    n_total++; if (rf_wreg !== 5'd7) $display("FAIL coal_proc_reg1: got %0d want 7", rf_wreg); else n_pass++;
    n_total++; if (io_busy !== 1'b1) $display("FAIL coal_busy: got %b want 1", io_busy); else n_pass++;
    tick;
    n_total++; if (buttons_db !== 6'h33) $display("FAIL coal_db2: got %h want 33", buttons_db); else n_pass++;
    n_total++; if (rf_wdata !== 32'h1234_5678) $display("FAIL coal_proc_data2: got %h want 12345678", rf_wdata); else n_pass++;
    proc_we = 1'b0;
    #1;
    n_total++; if (rf_we !== 1'b1) $display("FAIL coal_we: got %b want 1", rf_we); else n_pass++;
    n_total++; if (rf_wreg !== 5'd28) $display("FAIL coal_reg: got %0d want 28", rf_wreg); else n_pass++;
    n_total++; if (rf_wdata !== 32'h33) $display("FAIL coal_data: got %h want 00000033", rf_wdata); else n_pass++;
    n_total++; if (stall_req !== 1'b0) $display("FAIL coal_stall: got %b want 0", stall_req); else n_pass++;
    tick;
    n_total++; if (io_busy !== 1'b0) $display("FAIL coal_done_busy: got %b want 0", io_busy); else n_pass++;
    n_total++; if (rf_we !== 1'b0) $display("FAIL coal_done_we: got %b want 0", rf_we); else n_pass++;
  endtask

  task automatic test_starvation;
    tick;
    guitar_raw = 6'h32; proc_we = 1'b1; proc_wreg = 5'd9; proc_wdata = 32'hAAAA_5555;
    repeat (3) tick;
    vsync_n = 1'b0;
    tick; tick;
    n_total++; if (io_busy !== 1'b0) $display("FAIL starve_pre_busy: got %b want 0", io_busy); else n_pass++;
    tick;
    vsync_n = 1'b1;
    n_total++; if (io_busy !== 1'b1) $display("FAIL starve_busy: got %b want 1", io_busy); else n_pass++;
    for (int c = 1; c <= 3; c++) begin
      n_total++; if (stall_req !== 1'b0) $display("FAIL starve_blocked%0d_stall: got %b want 0", c, stall_req); else n_pass++;
      n_total++; if (rf_wreg !== 5'd9) $display("FAIL starve_blocked%0d_reg: got %0d want 9", c, rf_wreg); else n_pass++;
      if (c < 3) tick;
    end
    tick;
    n_total++; if (stall_req !== 1'b1) $display("FAIL starve_stall: got %b want 1", stall_req); else n_pass++;
    n_total++; if (rf_we !== 1'b1) $display("FAIL starve_we: got %b want 1", rf_we); else n_pass++;
    n_total++; if (rf_wreg !== 5'd28) $display("FAIL starve_reg: got %0d want 28", rf_wreg); else n_pass++;
    n_total++; if (rf_wdata !== 32'h32) $display("FAIL starve_data: got %h want 00000032", rf_wdata); else n_pass++;
    tick;
    n_total++; if (stall_req !== 1'b0) $display("FAIL starve_after_stall: got %b want 0", stall_req); else n_pass++;
    n_total++; if (io_busy !== 1'b1) $display("FAIL starve_frame_pending: got %b want 1", io_busy); else n_pass++;
    n_total++; if (rf_wdata !== 32'hAAAA_5555) $display("FAIL starve_proc_back: got %h want aaaa5555", rf_wdata); else n_pass++;
    tick; tick;
    n_total++; if (stall_req !== 1'b0) $display("FAIL starve2_blocked: got %b want 0", stall_req); else n_pass++;
    tick;
    n_total++; if (stall_req !== 1'b1) $display("FAIL starve2_stall: got %b want 1", stall_req); else n_pass++;
    n_total++; if (rf_wreg !== 5'd29) $display("FAIL starve2_reg: got %0d want 29", rf_wreg); else n_pass++;
    n_total++; if (rf_wdata !== 32'h2) $display("FAIL starve2_data: got %h want 00000002", rf_wdata); else n_pass++;
    tick;
    n_total++; if (stall_req !== 1'b0) $display("FAIL starve2_after: got %b want 0", stall_req); else n_pass++;
    n_total++; if (io_busy !== 1'b0) $display("FAIL starve2_busy: got %b want 0", io_busy); else n_pass++;
    proc_we = 1'b0;
  endtask

  task automatic test_passthrough;
    tick;
    proc_we = 1'b1; proc_wreg = 5'd5; proc_wdata = 32'hDEAD_BEEF;
    #1;
    n_total++; if (rf_we !== 1'b1) $display("FAIL pass_we: got %b want 1", rf_we); else n_pass++;
    n_total++; if (rf_wreg !== 5'd5) $display("FAIL pass_reg: got %0d want 5", rf_wreg); else n_pass++;
    n_total++; if (rf_wdata !== 32'hDEAD_BEEF) $display("FAIL pass_data: got %h want deadbeef", rf_wdata); else n_pass++;
    n_total++; if (io_busy !== 1'b0) $display("FAIL pass_busy: got %b want 0", io_busy); else n_pass++;
    tick;
    proc_wreg = 5'd28; proc_wdata = 32'hFFFF_FFFF;
    #1;
    n_total++; if (rf_wreg !== 5'd28) $display("FAIL pass_io_reg: got %0d want 28", rf_wreg); else n_pass++;
    n_total++; if (rf_wdata !== 32'hFFFF_FFFF) $display("FAIL pass_io_data: got %h want ffffffff", rf_wdata); else n_pass++;
    tick;
    proc_we = 1'b0;
    #1;
    n_total++; if (rf_we !== 1'b0) $display("FAIL pass_idle_we: got %b want 0", rf_we); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset;
    test_glitch;
    test_frame_wrap;
    test_priority_coalesce;
    test_starvation;
    test_passthrough;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
